load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Sits between the pipeline MEM stage and data_memory; data_memory is word-only (32b, 1-cycle registered read).
// - Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses: lane select, sign/zero extension,
//   read-modify-write (RMW) for sub-word stores.
// - Stalls the pipeline with req_ready while a multi-cycle access is in flight.
// PARAMETERS
// - DATA_WIDTH     32  data word width; only 32 supported
// - ADDRESS_WIDTH  30  word-address width of data_memory; mem_address = addr[ADDRESS_WIDTH+1:2]
// PORTS
// - clk           in   1   system clock, rising edge
// - rstN          in   1   asynchronous active-low reset
// - req_valid     in   1   access request from MEM stage
// - req_ready     out  1   1 = unit can accept; accept when req_valid & req_ready
// - is_store      in   1   1 = store, 0 = load
// - funct3        in   3   RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - addr          in   32  byte address
// - wdata         in   32  store data; low byte/half used for SB/SH
// - rdata         out  32  extended load result
// - rdata_valid   out  1   one-cycle pulse, rdata valid
// - store_done    out  1   one-cycle pulse, write presented to memory
// - misaligned    out  1   one-cycle pulse, misaligned request (MISALIGN_TRAP_EN only)
// - mem_read_En   out  1   to data_memory read_En
// - mem_write_En  out  1   to data_memory write_En
// - mem_address   out  ADDRESS_WIDTH  to data_memory address
// - mem_data_in   out  32  to data_memory data_in
// - mem_data_out  in   32  from data_memory data_out; valid the cycle after mem_read_En
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, rdata=0, all pulse and mem_* outputs 0, internal latches cleared.
// - FSM: IDLE, LOAD_WAIT, RMW_WAIT, RMW_WRITE. req_ready=1 only in IDLE.
// - Accept at cycle T latches addr[1:0], funct3, wdata, word address.
//   In T, mem_* is driven combinationally from the request inputs.
// - SW: T mem_write_En=1, mem_data_in=wdata, store_done=1; stay IDLE; 1 cycle total.
// - Load: T mem_read_En=1 -> LOAD_WAIT.
//   T+1: select lane by latched addr[1:0]; B uses byte addr[1:0], H uses half addr[1].
//   T+1: sign-extend (B/H) or zero-extend (BU/HU); register into rdata -> IDLE.
//   T+2: rdata_valid=1; rdata holds value until next load completes.
// - SB/SH: T mem_read_En=1 -> RMW_WAIT.
//   T+1: merge wdata lane into mem_data_out, register -> RMW_WRITE.
//   T+2: mem_write_En=1, mem_data_in=merged word, latched address, store_done=1 -> IDLE.
//   New request accepted at T+3 earliest.
// - mem_read_En and mem_write_En are never both 1. mem_address and mem_data_in are 0 when not accessing.
// - funct3[1:0]=11 is treated as W. funct3[2] is ignored for stores.
// - Back-to-back: request at T+3 after RMW sees the written word; no forwarding needed.
// - Reset mid-operation: abandon. A pending RMW write is never issued; rdata_valid/store_done are not pulsed.
// - req_valid low in IDLE: no memory activity.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - H/HU with addr[0]=1, or W with addr[1:0]!=0, pulses misaligned in T.
//   - No memory access, no rdata_valid/store_done; stay IDLE.
// - MISALIGN_TRAP_EN undefined:
//   - misaligned tied 0; offending low address bits are forced to 0 (H uses addr[1] only, W ignores addr[1:0]).
// TESTING
// - mem[5]=0x8899AABB; LB addr 0x17 -> rdata_valid at T+2, rdata=0xFFFFFF88; LBU addr 0x17 -> 0x00000088.
// - mem[5]=0x8899AABB; LH addr 0x14 -> 0xFFFFAABB; LHU addr 0x16 -> 0x00008899; LW addr 0x14 -> 0x8899AABB.
// - mem[2]=0x11223344; SB addr 0x09 wdata 0xFF -> T+2 write 0x1122FF44 to addr 2, store_done at T+2, req_ready=0 T+1..T+2.
// - SW addr 0x20 wdata 0xDEADBEEF -> T write, store_done at T, then LW 0x20 -> 0xDEADBEEF.
// - SH addr 0x0A, rstN low at T+1 -> no mem_write_En, mem[2] unchanged, req_ready=1 after release.
// - With MISALIGN_TRAP_EN, LW addr 0x13 -> misaligned at T, no mem_read_En; without it -> reads word 4.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store lane handling and sub-word RMW in front of a word-only data memory.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     rdata_valid,
    output logic                     store_done,
    output logic                     misaligned,
    output logic                     mem_read_En,
    output logic                     mem_write_En,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RMW_WAIT,
        RMW_WRITE
    } state_t;

    state_t                   state;
    logic [1:0]               lat_off;
    logic [2:0]               lat_f3;
    logic [15:0]              lat_wdata;
    logic [ADDRESS_WIDTH-1:0] lat_word_addr;
    logic [31:0]              merged;

    logic accept;
    logic is_word;
    logic is_half;
    logic misaligned_req;
    logic go;

    // funct3[1] set means a word access (covers 010 and the 011 alias).
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        if (f3[1])
            load_extend = word;
        else if (f3[0])
            load_extend = f3[2] ? {16'h0000, h} : {{16{h[15]}}, h};
        else
            load_extend = f3[2] ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic        half,
                                                input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (half) begin
            if (off[1]) m[31:16] = wd;
            else        m[15:0]  = wd;
        end else begin
            case (off)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end
        store_merge = m;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);
    assign is_word   = funct3[1];
    assign is_half   = (funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    assign misaligned_req = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    assign go = accept && !misaligned_req;

    // The request cycle drives memory straight from the inputs to save a cycle.
    always_comb begin
        misaligned   = accept && misaligned_req;
        mem_read_En  = 1'b0;
        mem_write_En = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        store_done   = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    mem_address = addr[ADDRESS_WIDTH+1:2];
                    if (is_store && is_word) begin
                        mem_write_En = 1'b1;
                        mem_data_in  = wdata;
                        store_done   = 1'b1;
                    end else begin
                        mem_read_En = 1'b1;
                    end
                end
            end
            RMW_WRITE: begin
                mem_write_En = 1'b1;
                mem_address  = lat_word_addr;
                mem_data_in  = merged;
                store_done   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state         <= IDLE;
            rdata         <= '0;
            rdata_valid   <= 1'b0;
            lat_off       <= '0;
            lat_f3        <= '0;
            lat_wdata     <= '0;
            lat_word_addr <= '0;
            merged        <= '0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        lat_off       <= addr[1:0];
                        lat_f3        <= funct3;
                        lat_wdata     <= wdata[15:0];
                        lat_word_addr <= addr[ADDRESS_WIDTH+1:2];
                        if (!is_store)
                            state <= LOAD_WAIT;
                        else if (!is_word)
                            state <= RMW_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    rdata       <= load_extend(mem_data_out, lat_off, lat_f3);
                    rdata_valid <= 1'b1;
                    state       <= IDLE;
                end
                RMW_WAIT: begin
                    merged <= store_merge(mem_data_out, lat_off, lat_f3[0], lat_wdata);
                    state  <= RMW_WRITE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven bench for load_store_unit with a word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        store_done;
    logic        misaligned;
    logic        mem_read_En;
    logic        mem_write_En;
    logic [29:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] tb_mem [64];

    int errors = 0;
    int checks = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .store_done   (store_done),
        .misaligned   (misaligned),
        .mem_read_En  (mem_read_En),
        .mem_write_En (mem_write_En),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_En) tb_mem[mem_address[5:0]] <= mem_data_in;
        if (mem_read_En)  mem_data_out <= tb_mem[mem_address[5:0]];
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        req_valid = 1'b1;
        is_store  = v.st;
        funct3    = v.f3;
        addr      = v.a;
        wdata     = v.wd;
        #1;
        check({tag, " req_ready@T"}, {31'd0, req_ready}, 32'd1);
        if (!v.st) begin
            check({tag, " read_En@T"}, {31'd0, mem_read_En}, 32'd1);
            check({tag, " address@T"}, {2'b00, mem_address}, {2'b00, v.a[31:2]});
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
            check({tag, " req_ready@T+1"}, {31'd0, req_ready}, 32'd0);
            check({tag, " rdata_valid@T+1"}, {31'd0, rdata_valid}, 32'd0);
            @(negedge clk);
            check({tag, " rdata_valid@T+2"}, {31'd0, rdata_valid}, 32'd1);
            check({tag, " rdata"}, rdata, v.exp);
        end else if (v.f3[1]) begin
            check({tag, " write_En@T"}, {31'd0, mem_write_En}, 32'd1);
            check({tag, " read_En@T"}, {31'd0, mem_read_En}, 32'd0);
            check({tag, " data_in@T"}, mem_data_in, v.wd);
            check({tag, " store_done@T"}, {31'd0, store_done}, 32'd1);
            @(posedge clk); #1 req_valid = 1'b0;
            check({tag, " mem word"}, tb_mem[v.a[7:2]], v.exp);
        end else begin
            check({tag, " read_En@T"}, {31'd0, mem_read_En}, 32'd1);
            check({tag, " write_En@T"}, {31'd0, mem_write_En}, 32'd0);
            @(posedge clk); #1 req_valid = 1'b0;
            @(negedge clk);
            check({tag, " req_ready@T+1"}, {31'd0, req_ready}, 32'd0);
            check({tag, " write_En@T+1"}, {31'd0, mem_write_En}, 32'd0);
            check({tag, " store_done@T+1"}, {31'd0, store_done}, 32'd0);
            @(negedge clk);
            check({tag, " req_ready@T+2"}, {31'd0, req_ready}, 32'd0);
            check({tag, " write_En@T+2"}, {31'd0, mem_write_En}, 32'd1);
            check({tag, " store_done@T+2"}, {31'd0, store_done}, 32'd1);
            check({tag, " address@T+2"}, {2'b00, mem_address}, {2'b00, v.a[31:2]});
            check({tag, " data_in@T+2"}, mem_data_in, v.exp);
            @(posedge clk); #1;
            check({tag, " mem word"}, tb_mem[v.a[7:2]], v.exp);
        end
    endtask

    initial begin
        vec_t hold_v;
        vecs[0]  = '{1'b1, 3'b010, 32'h14, 32'h8899AABB, 32'h8899AABB};
        vecs[1]  = '{1'b1, 3'b010, 32'h08, 32'h11223344, 32'h11223344};
        vecs[2]  = '{1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3]  = '{1'b0, 3'b000, 32'h17, 32'h0,        32'hFFFFFF88};
        vecs[4]  = '{1'b0, 3'b100, 32'h17, 32'h0,        32'h00000088};
        vecs[5]  = '{1'b0, 3'b001, 32'h14, 32'h0,        32'hFFFFAABB};
        vecs[6]  = '{1'b0, 3'b101, 32'h16, 32'h0,        32'h00008899};
        vecs[7]  = '{1'b0, 3'b010, 32'h14, 32'h0,        32'h8899AABB};
        vecs[8]  = '{1'b0, 3'b000, 32'h14, 32'h0,        32'hFFFFFFBB};
        vecs[9]  = '{1'b0, 3'b100, 32'h15, 32'h0,        32'h000000AA};
        vecs[10] = '{1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFF8899};
        vecs[11] = '{1'b0, 3'b011, 32'h14, 32'h0,        32'h8899AABB};
        vecs[12] = '{1'b1, 3'b000, 32'h09, 32'h000000FF, 32'h1122FF44};
        vecs[13] = '{1'b1, 3'b001, 32'h0A, 32'h1234ABCD, 32'hABCDFF44};
        vecs[14] = '{1'b1, 3'b100, 32'h0B, 32'h00000077, 32'h77CDFF44};
        vecs[15] = '{1'b0, 3'b000, 32'h0B, 32'h0,        32'h00000077};
        vecs[16] = '{1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[17] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hDEADBEEF};
        vecs[18] = '{1'b0, 3'b101, 32'h08, 32'h0,        32'h0000FF44};

        rstN      = 1'b0;
        req_valid = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;

        repeat (2) @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rdata", rdata, 32'h0);
        check("reset rdata_valid", {31'd0, rdata_valid}, 32'd0);
        check("reset store_done", {31'd0, store_done}, 32'd0);
        check("reset mem_en", {30'd0, mem_read_En, mem_write_En}, 32'd0);
        check("reset mem_address", {2'b00, mem_address}, 32'd0);
        check("reset mem_data_in", mem_data_in, 32'd0);
        rstN = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle no access", {30'd0, mem_read_En, mem_write_En}, 32'd0);
            check("idle misaligned", {31'd0, misaligned}, 32'd0);
        end

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);

        // A store must leave the last load result in place.
        hold_v = '{1'b1, 3'b010, 32'h24, 32'h01020304, 32'h01020304};
        run_vec(19, hold_v);
        check("rdata hold", rdata, 32'h0000FF44);
        check("rdata_valid after store", {31'd0, rdata_valid}, 32'd0);

        // Reset in the middle of an SH read-modify-write.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b001;
        addr = 32'h0A; wdata = 32'h00005555;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        #1;
        check("midrst req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst write_En", {31'd0, mem_write_En}, 32'd0);
            check("midrst store_done", {31'd0, store_done}, 32'd0);
        end
        rstN = 1'b1;
        @(negedge clk);
        check("midrst req_ready after", {31'd0, req_ready}, 32'd1);
        check("midrst mem[2]", tb_mem[2], 32'h77CDFF44);
        check("midrst rdata", rdata, 32'h0);

        // LW at a misaligned address.
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h13;
        #1;
`ifdef MISALIGN_TRAP_EN
        check("mis pulse", {31'd0, misaligned}, 32'd1);
        check("mis read_En", {31'd0, mem_read_En}, 32'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        check("mis req_ready", {31'd0, req_ready}, 32'd1);
        check("mis pulse gone", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        check("mis rdata_valid", {31'd0, rdata_valid}, 32'd0);
`else
        check("mis pulse", {31'd0, misaligned}, 32'd0);
        check("mis read_En", {31'd0, mem_read_En}, 32'd1);
        check("mis address", {2'b00, mem_address}, 32'd4);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mis rdata_valid", {31'd0, rdata_valid}, 32'd1);
        check("mis rdata", rdata, 32'hCAFEF00D);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
